// File: rtl/light_fade_selector.sv
`default_nettype none
// ============================================================================
// Module   : light_fade_selector
// Brief    : Button-stepped colour index with a saturating white/colour crossfade.
// Revision : 1.0 - initial release
// ============================================================================
module light_fade_selector #(
    parameter int CH_W      = 8,
    parameter int W_W       = 4,
    parameter int STEP      = 1,
    parameter int N_COLOURS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sel,
    input  logic                button,
    output logic [3*CH_W-1:0]   light,
    output logic [2:0]          colour,
    output logic                busy
);

    localparam int              c_FULL   = 2**W_W;
    localparam int              c_MW     = CH_W + W_W + 1;
    localparam logic [CH_W-1:0] c_CH_MAX = '1;
    localparam logic [W_W:0]    c_FULL_W = (W_W+1)'(c_FULL);
    localparam logic [W_W+1:0]  c_FULL_X = (W_W+2)'(c_FULL);
    localparam logic [W_W+1:0]  c_STEP_X = (W_W+2)'(STEP);

    logic [W_W:0]        wgt_q, wgt_d;
    logic [2:0]          colour_q, colour_d;
    logic                button_q, button_d;
    logic [3*CH_W-1:0]   light_q, light_d;

    logic                w_edge;
    logic [W_W+1:0]      w_wgt_x;
    logic [W_W+1:0]      w_up;
    logic [W_W+1:0]      w_dn;
    logic [W_W:0]        w_inv;
    logic [3*CH_W-1:0]   w_mix;

    assign w_edge  = button & ~button_q;
    // Saturation arithmetic is done one bit wider so w+STEP can never wrap.
    assign w_wgt_x = {1'b0, wgt_q};
    assign w_up    = w_wgt_x + c_STEP_X;
    assign w_dn    = w_wgt_x - c_STEP_X;
    assign w_inv   = c_FULL_W - wgt_q;

    always_comb begin
        button_d = button;
        colour_d = colour_q;
        if (w_edge) begin
            colour_d = (colour_q == 3'(N_COLOURS)) ? 3'd1 : colour_q + 3'd1;
        end

        wgt_d = wgt_q;
        if (sel && (wgt_q != c_FULL_W)) begin
            wgt_d = (w_up > c_FULL_X) ? c_FULL_W : w_up[W_W:0];
        end else if (!sel && (wgt_q != '0)) begin
            wgt_d = (w_wgt_x < c_STEP_X) ? '0 : w_dn[W_W:0];
        end

        light_d = w_mix;
    end

    // Channel 0 is blue (colour bit 0), channel 2 is red (colour bit 2).
    generate
        for (genvar ch = 0; ch < 3; ch++) begin : g_ch
            logic [CH_W-1:0] w_c_ch;
            logic [c_MW-1:0] w_white_p;
            logic [c_MW-1:0] w_col_p;
            logic [c_MW-1:0] w_sum;

            assign w_c_ch    = colour_q[ch] ? c_CH_MAX : '0;
            assign w_white_p = {{(c_MW-CH_W){1'b0}}, c_CH_MAX}
                             * {{(c_MW-W_W-1){1'b0}}, w_inv};
            assign w_col_p   = {{(c_MW-CH_W){1'b0}}, w_c_ch}
                             * {{(c_MW-W_W-1){1'b0}}, wgt_q};
            assign w_sum     = w_white_p + w_col_p;
            assign w_mix[ch*CH_W +: CH_W] = CH_W'(w_sum >> W_W);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wgt_q    <= '0;
            colour_q <= 3'd1;
            button_q <= 1'b0;
            light_q  <= '1;
        end else begin
            wgt_q    <= wgt_d;
            colour_q <= colour_d;
            button_q <= button_d;
            light_q  <= light_d;
        end
    end

    assign light  = light_q;
    assign colour = colour_q;
    assign busy   = (sel & (wgt_q != c_FULL_W)) | (~sel & (wgt_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_light_fade_selector.sv
`default_nettype none
// ============================================================================
// Module   : tb_light_fade_selector
// Brief    : Vector-table bench for light_fade_selector (STEP=1 and STEP=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_light_fade_selector;

    logic        clk = 1'b0;
    logic        rst, sel, button, sel3, button3;
    logic [23:0] light, light3;
    logic [2:0]  colour, colour3;
    logic        busy, busy3;

    always #5 clk = ~clk;

    light_fade_selector #(.CH_W(8), .W_W(4), .STEP(1), .N_COLOURS(6)) dut (
        .clk(clk), .rst(rst), .sel(sel), .button(button),
        .light(light), .colour(colour), .busy(busy)
    );

    light_fade_selector #(.CH_W(8), .W_W(4), .STEP(3), .N_COLOURS(6)) dut3 (
        .clk(clk), .rst(rst), .sel(sel3), .button(button3),
        .light(light3), .colour(colour3), .busy(busy3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected crossfade of white and the full colour word at weight w (CH_W=8, W_W=4).
    function automatic logic [23:0] mix(input int w, input logic [2:0] c);
        logic [23:0] r;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            int cv;
            int v;
            cv = c[ch] ? 255 : 0;
            v  = (255 * (16 - w) + cv * w) >> 4;
            r[ch*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    typedef struct {
        logic        sel;
        logic        btn;
        logic [23:0] light;
        logic [2:0]  colour;
        logic        busy;
    } vec_t;

    vec_t        vq[$];
    int          fw;
    logic [2:0]  fc;
    logic        fbq;

    // Appends one clock of stimulus with the expectation seen just after that edge.
    task automatic add(input logic s, input logic b);
        vec_t v;
        v.sel   = s;
        v.btn   = b;
        v.light = mix(fw, fc);
        if (b && !fbq) fc = (fc == 3'd6) ? 3'd1 : fc + 3'd1;
        fbq = b;
        if (s && fw < 16) fw++;
        else if (!s && fw > 0) fw--;
        v.colour = fc;
        v.busy   = s ? (fw != 16) : (fw != 0);
        vq.push_back(v);
    endtask

    initial begin
        int ups[7];
        int dns[7];
        int prev;

        rst = 1'b0; sel = 1'b0; button = 1'b0; sel3 = 1'b0; button3 = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset light", light, 24'hFFFFFF);
        chk("reset colour", colour, 3'd1);
        chk("reset busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 chk("reset held light", light, 24'hFFFFFF);
        @(negedge clk) rst = 1'b0;

        fw = 0; fc = 3'd1; fbq = 1'b0;
        repeat (20) add(1'b0, 1'b0);
        repeat (18) add(1'b1, 1'b0);
        repeat (7) begin add(1'b1, 1'b1); add(1'b1, 1'b0); end
        repeat (10) add(1'b1, 1'b1);
        add(1'b1, 1'b0);
        repeat (18) add(1'b0, 1'b0);
        repeat (5) add(1'b1, 1'b0);
        add(1'b0, 1'b1);
        repeat (5) add(1'b0, 1'b0);

        foreach (vq[i]) begin
            @(negedge clk);
            sel    = vq[i].sel;
            button = vq[i].btn;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d light", i), light, vq[i].light);
            chk($sformatf("vec%0d colour", i), colour, vq[i].colour);
            chk($sformatf("vec%0d busy", i), busy, vq[i].busy);
            if (i == 28) chk("fade midpoint light", light, 24'h7F7FFF);
            if (i == 36) chk("fade settled light", light, 24'h0000FF);
            if (i == 39) chk("first advance light", light, 24'h00FF00);
        end

        // STEP=3 saturating ramp up and down, observed through the lagging light word.
        ups  = '{3, 6, 9, 12, 15, 16, 16};
        dns  = '{13, 10, 7, 4, 1, 0, 0};
        prev = 0;
        @(negedge clk) sel3 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("step3 up%0d light", k), light3, mix(prev, 3'd1));
            chk($sformatf("step3 up%0d busy", k), busy3, ups[k] != 16);
            prev = ups[k];
        end
        @(negedge clk) sel3 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("step3 dn%0d light", k), light3, mix(prev, 3'd1));
            chk($sformatf("step3 dn%0d busy", k), busy3, dns[k] != 0);
            prev = dns[k];
        end

        // Asynchronous reset at w=9, between clock edges.
        @(negedge clk) sel = 1'b1;
        repeat (9) @(posedge clk);
        #1 chk("pre-reset light", light, mix(8, 3'd4));
        #1 rst = 1'b1;
        #1;
        chk("async reset light", light, 24'hFFFFFF);
        chk("async reset colour", colour, 3'd1);
        chk("async reset busy", busy, 1'b1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 chk("restart w1 light", light, 24'hFFFFFF);
        @(posedge clk);
        #1 chk("restart w2 light", light, 24'hEFEFFF);
        chk("restart colour", colour, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
